// File: rtl/uart_pkg.sv
// Shared types, widths and timing helper for the UART receive path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Whole core-clock cycles per serial bit (integer division).
  function automatic int bit_cycles(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic circular-buffer FIFO with occupancy count and full/empty flags.
// Latency: a written entry is visible at rd_dat the cycle after the write edge.
// Backpressure: a write while full is refused unless a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     core_clk,
  input  logic                     arst_n,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic             pop;
  logic             push;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign pop    = rd_rdy && !empty;
  // A same-cycle read frees the slot, so a write into a full FIFO is still accepted.
  assign push   = wr_vld && (!full || pop);
  // Head entry is forced to zero when empty so the output is defined out of reset.
  assign rd_dat = empty ? '0 : mem[head];
  assign count  = cnt;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Storage array; contents need no reset because empty masks the output.
  always_ff @(posedge core_clk) begin
    if (push) mem[tail] <= wr_dat;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a byte FIFO, sticky overflow/framing flags.
// Latency: 2-cycle line synchroniser; byte visible on data_out 1 cycle after the stop-bit sample.
// Backpressure: data_out_valid/data_out_ready; a byte arriving into a full FIFO with no pop is dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  output logic [DATA_W-1:0]             data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clear_err
);

  localparam int BIT_CYC  = bit_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int IDX_W    = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  logic              rx_meta;
  logic              rx_s;
  logic              rx_prev;
  logic [1:0]        sync_fill;
  logic              rx_fall;

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic              brk;
  logic              brk_nxt;
  logic              rx_push;
  logic              ferr_set;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              ovf_set;

  // Two-flop synchroniser preset to idle-high; sync_fill tracks when rx_s holds a real line sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
      rx_prev   <= 1'b0;
    end else begin
      rx_meta   <= serial_in;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      // Only a genuinely observed high counts, so a line held low across reset cannot look like a start edge.
      rx_prev   <= rx_s & sync_fill[1];
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

  // Receive state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state, bit timing and byte assembly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = bit_idx;
    shreg_nxt = shreg;
    brk_nxt   = brk;
    rx_push   = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rx_fall) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          // A start bit that is high again at mid-bit was line noise.
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt   = '0;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[DATA_W-1:1]};
          idx_nxt   = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (brk) begin
          // Hold off after a bad stop bit until the line idles, so a break is not seen as a new start.
          cnt_nxt = '0;
          if (rx_s) begin
            brk_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end else if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            rx_push   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set = 1'b1;
            brk_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter, bit index, shift register and break-wait flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      brk     <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bit_idx <= idx_nxt;
      shreg   <= shreg_nxt;
      brk     <= brk_nxt;
    end
  end

  assign data_out_valid = !fifo_empty;
  assign fifo_pop       = data_out_valid && data_out_ready;
  assign ovf_set        = rx_push && fifo_full && !fifo_pop;

  // Sticky error flags; a new error in the same cycle as clear_err keeps its flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= ovf_set  | (overflow  & ~clear_err);
      frame_err <= ferr_set | (frame_err & ~clear_err);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .core_clk (clk),
    .arst_n   (rst),
    .wr_vld   (rx_push),
    .wr_dat   (shreg),
    .rd_rdy   (data_out_ready),
    .rd_dat   (data_out),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a byte-queue reference model.
// Latency: frames are driven at bit level; results are checked once each frame has fully ended.
// Backpressure: data_out_ready is driven low while filling and high while draining or at a chosen edge.
module tb_uart_rx_fifo;

  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 2_000_000;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CYC    = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_CYC   = BIT_CYC / 2;
  // Clock edges from the start-bit edge to the stop-bit sample: 2 synchroniser
  // cycles, half a bit to the start-bit centre, then nine whole bits.
  localparam int STOP_EDGE  = 2 + HALF_CYC + 9 * BIT_CYC;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       frame_err;
  logic       clear_err;

  int checks;
  int errors;

  // Reference model: queued bytes and the two sticky flags.
  logic [7:0] mq[$];
  logic [7:0] got_q[$];
  logic       m_ovf;
  logic       m_ferr;

  uart_rx_fifo #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .frame_err      (frame_err),
    .clear_err      (clear_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Effect of one complete frame on the model.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit pop_same);
    if (!stop_ok) begin
      m_ferr = 1'b1;
    end else begin
      if (pop_same && mq.size() > 0) void'(mq.pop_front());
      if (mq.size() < FIFO_DEPTH) mq.push_back(b);
      else m_ovf = 1'b1;
    end
  endtask

  // Drive one 8N1 frame. mode 1: pulse ready at the stop-sample edge.
  // mode 2: hold clear_err from frame start through the stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int mode);
    int k;
    for (int c = 0; c < 10 * BIT_CYC; c++) begin
      k = c / BIT_CYC;
      if (k == 0)      serial_in = 1'b0;
      else if (k == 9) serial_in = stop_bit;
      else             serial_in = b[k-1];
      if (mode == 1) data_out_ready = (c == STOP_EDGE);
      if (mode == 2) clear_err = (c <= STOP_EDGE);
      @(negedge clk);
    end
    serial_in      = 1'b1;
    data_out_ready = 1'b0;
    clear_err      = 1'b0;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Pop with ready held high while valid, recording each byte; bounded.
  task automatic pop_all;
    got_q.delete();
    for (int i = 0; i < 2 * FIFO_DEPTH && data_out_valid; i++) begin
      got_q.push_back(data_out);
      data_out_ready = 1'b1;
      @(negedge clk);
    end
    data_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    data_out_ready = 1'b0;
    clear_err = 1'b0;
    repeat (20) begin
      serial_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if ({data_out_valid, overflow, frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid/ovf/ferr=%b, expected 000", {data_out_valid, overflow, frame_err});
    end
    checks++;
    if (data_out !== 8'h00 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%02h count=%0d, expected data=00 count=0", data_out, fifo_count);
    end
    idle(BIT_CYC);
    rst = 1'b1;
    idle(BIT_CYC);
    send_frame(8'h55, 1'b1, 0);
    model_frame(8'h55, 1'b1, 1'b0);
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== mq[0] || fifo_count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL first_frame: got valid=%b data=%02h count=%0d, expected 1 %02h %0d",
               data_out_valid, data_out, fifo_count, mq[0], mq.size());
    end
    pop_all();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
      errors++;
      $display("FAIL first_pop: got %0d bytes, expected the single byte 55", got_q.size());
    end
    mq.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat [4];
    logic [7:0] exp_q[$];
    pat = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    foreach (pat[i]) begin
      send_frame(pat[i], 1'b1, 0);
      model_frame(pat[i], 1'b1, 1'b0);
    end
    checks++;
    if (fifo_count !== 4'(mq.size()) || data_out !== mq[0]) begin
      errors++;
      $display("FAIL b2b_fill: got count=%0d head=%02h, expected %0d %02h", fifo_count, data_out, mq.size(), mq[0]);
    end
    exp_q = mq;
    pop_all();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_len: got %0d consecutive pops, expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_pop%0d: got %02h, expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (data_out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL b2b_empty: got valid=%b count=%0d, expected 0 0", data_out_valid, fifo_count);
    end
    mq.delete();
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 0);
      model_frame(b, 1'b1, 1'b0);
    end
    checks++;
    if (fifo_count !== 4'(mq.size()) || overflow !== m_ovf || data_out !== mq[0]) begin
      errors++;
      $display("FAIL ovf_full: got count=%0d ovf=%b head=%02h, expected %0d %b %02h",
               fifo_count, overflow, data_out, mq.size(), m_ovf, mq[0]);
    end
    pulse_clear();
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b, expected %b", overflow, m_ovf);
    end
    exp_q = mq;
    pop_all();
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL ovf_drain: got %0d bytes (first %02h), expected %0d (first %02h)",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q.size(), exp_q[0]);
    end
    mq.delete();
  endtask

  task automatic test_frame_err;
    send_frame(8'h81, 1'b0, 0);
    model_frame(8'h81, 1'b0, 1'b0);
    idle(BIT_CYC);
    checks++;
    if (frame_err !== m_ferr || fifo_count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL ferr_set: got ferr=%b count=%0d, expected %b %0d", frame_err, fifo_count, m_ferr, mq.size());
    end
    send_frame(8'h42, 1'b1, 0);
    model_frame(8'h42, 1'b1, 1'b0);
    checks++;
    if (data_out !== mq[0] || fifo_count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL ferr_recover: got data=%02h count=%0d, expected %02h %0d", data_out, fifo_count, mq[0], mq.size());
    end
    pop_all();
    mq.delete();
    // clear_err held across the bad stop-bit sample: the new error must survive.
    send_frame(8'($urandom_range(0, 255)), 1'b0, 2);
    m_ferr = 1'b1;
    idle(BIT_CYC);
    checks++;
    if (frame_err !== m_ferr) begin
      errors++;
      $display("FAIL ferr_beats_clear: got ferr=%b, expected %b", frame_err, m_ferr);
    end
    pulse_clear();
    checks++;
    if (frame_err !== m_ferr) begin
      errors++;
      $display("FAIL ferr_clear: got ferr=%b, expected %b", frame_err, m_ferr);
    end
  endtask

  task automatic test_glitch;
    int len;
    for (int g = 0; g < 3; g++) begin
      len = $urandom_range(1, HALF_CYC - 2);
      serial_in = 1'b0;
      repeat (len) @(negedge clk);
      idle(11 * BIT_CYC);
      checks++;
      if (fifo_count !== 4'd0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL glitch%0d_len%0d: got count=%0d ferr=%b ovf=%b, expected 0 0 0",
                 g, len, fifo_count, frame_err, overflow);
      end
    end
    send_frame(8'h7E, 1'b1, 0);
    model_frame(8'h7E, 1'b1, 1'b0);
    checks++;
    if (data_out !== mq[0] || fifo_count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL glitch_after: got data=%02h count=%0d, expected %02h %0d", data_out, fifo_count, mq[0], mq.size());
    end
    pop_all();
    mq.delete();
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    bit         ok;
    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, logic'(ok), 0);
      model_frame(b, ok, 1'b0);
      if (!ok) idle(BIT_CYC);
    end
    checks++;
    if (fifo_count !== 4'(mq.size()) || frame_err !== m_ferr || overflow !== m_ovf) begin
      errors++;
      $display("FAIL rand_state: got count=%0d ferr=%b ovf=%b, expected %0d %b %b",
               fifo_count, frame_err, overflow, mq.size(), m_ferr, m_ovf);
    end
    exp_q = mq;
    pop_all();
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL rand_drain: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
    mq.delete();
    pulse_clear();
  endtask

  task automatic test_full_simul;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 0);
      model_frame(b, 1'b1, 1'b0);
    end
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 1);
    model_frame(b, 1'b1, 1'b1);
    checks++;
    if (fifo_count !== 4'(mq.size()) || overflow !== m_ovf || data_out !== mq[0]) begin
      errors++;
      $display("FAIL simul_push_pop: got count=%0d ovf=%b head=%02h, expected %0d %b %02h",
               fifo_count, overflow, data_out, mq.size(), m_ovf, mq[0]);
    end
    exp_q = mq;
    pop_all();
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL simul_drain: got %0d bytes (last %02h), expected %0d (last %02h)",
               got_q.size(), (got_q.size() > 0) ? got_q[$] : 8'hxx, exp_q.size(), exp_q[$]);
    end
    mq.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    send_frame(8'h99, 1'b1, 0);
    // Start a frame of zero bits and reset while the line is low during DATA.
    serial_in = 1'b0;
    repeat (4 * BIT_CYC) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (fifo_count !== 4'd0 || data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold: got count=%0d valid=%b, expected 0 0", fifo_count, data_out_valid);
    end
    rst = 1'b1;
    mq.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    repeat (3 * BIT_CYC) @(negedge clk);
    idle(12 * BIT_CYC);
    checks++;
    if (fifo_count !== 4'd0 || data_out_valid !== 1'b0 || frame_err !== m_ferr) begin
      errors++;
      $display("FAIL midreset_spurious: got count=%0d valid=%b ferr=%b, expected 0 0 %b",
               fifo_count, data_out_valid, frame_err, m_ferr);
    end
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 0);
    model_frame(b, 1'b1, 1'b0);
    checks++;
    if (data_out !== mq[0] || fifo_count !== 4'(mq.size())) begin
      errors++;
      $display("FAIL midreset_recover: got data=%02h count=%0d, expected %02h %0d", data_out, fifo_count, mq[0], mq.size());
    end
    pop_all();
    mq.delete();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    m_ovf          = 1'b0;
    m_ferr         = 1'b0;
    rst            = 1'b0;
    serial_in      = 1'b1;
    data_out_ready = 1'b0;
    clear_err      = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_random();
    test_full_simul();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
